// File: rtl/accum_arbiter.sv
// accum_arbiter: round-robin scheduler sharing one accum datapath between two requesters
//
// Per burst the winner gets one accum clear cycle, then len+1 RUN beats where
// its operand pair is steered onto acc_din1/acc_din2, then one DRAIN cycle
// after which the accum result and overflow are captured and done pulses.
//
// Ports:
//   clock_i                 system clock, rising edge
//   reset_i                 asynchronous, active-low reset
//   req0_i, req1_i          burst requests, held until the matching gnt is seen
//   len0_i, len1_i          burst length minus one, sampled in the grant cycle
//   a0_i, b0_i, a1_i, b1_i  operand pairs, valid while the matching gnt is high
//   gnt0_o, gnt1_o          high on every RUN beat of that requester's burst
//   acc_clear_o             accum clear, high for the single CLEAR cycle
//   acc_din1_o, acc_din2_o  accum data inputs, zero outside RUN
//   acc_result_i, acc_ovf_i accum result and sticky overflow
//   busy_o                  high in any state other than IDLE
//   done_o                  one-cycle pulse; done_id_o/result_o/result_ovf_o valid
//   done_id_o               requester that owned the finished burst
//   result_o, result_ovf_o  captured accum result/overflow, held until next done
//
// Build option: ACCUM_ARB_OVF_ABORT_EN ends a burst early when acc_ovf_i is
// seen high during RUN; without it overflow is only reported via result_ovf_o.
module accum_arbiter #(
    parameter int WIDTH = 8,
    parameter int LENW  = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [LENW-1:0]  len0_i,
    input  logic [LENW-1:0]  len1_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] b0_i,
    input  logic [WIDTH-1:0] a1_i,
    input  logic [WIDTH-1:0] b1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             acc_clear_o,
    output logic [WIDTH-1:0] acc_din1_o,
    output logic [WIDTH-1:0] acc_din2_o,
    input  logic [WIDTH-1:0] acc_result_i,
    input  logic             acc_ovf_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             done_id_o,
    output logic [WIDTH-1:0] result_o,
    output logic             result_ovf_o
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [LENW-1:0]  cnt_q, cnt_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             clear_q, clear_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             rovf_q, rovf_d;
    logic             win;
    logic             abort;

    // Sole requester wins; on a tie the one not served last time wins.
    assign win = (req0_i && req1_i) ? ~last_q : req1_i;

`ifdef ACCUM_ARB_OVF_ABORT_EN
    assign abort = acc_ovf_i;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;
        rovf_d    = rovf_q;
        case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    state_d = CLEAR;
                    owner_d = win;
                    last_d  = win;
                    cnt_d   = win ? len1_i : len0_i;
                end
            end
            CLEAR: state_d = RUN;
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0 || abort) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                state_d   = IDLE;
                done_d    = 1'b1;
                done_id_d = owner_q;
                result_d  = acc_result_i;
                rovf_d    = acc_ovf_i;
            end
            default: state_d = IDLE;
        endcase
        // Control outputs are decoded from the next state so they come straight off flops.
        gnt0_d  = (state_d == RUN) && !owner_d;
        gnt1_d  = (state_d == RUN) && owner_d;
        clear_d = state_d == CLEAR;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            clear_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            result_q  <= '0;
            rovf_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            clear_q   <= clear_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
            rovf_q    <= rovf_d;
        end
    end

    // Operands pass through unmodified during the owner's beats so the pair
    // presented while gnt is high is the pair the accum registers.
    assign acc_din1_o = gnt0_q ? a0_i : (gnt1_q ? a1_i : '0);
    assign acc_din2_o = gnt0_q ? b0_i : (gnt1_q ? b1_i : '0);

    assign gnt0_o       = gnt0_q;
    assign gnt1_o       = gnt1_q;
    assign acc_clear_o  = clear_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign done_id_o    = done_id_q;
    assign result_o     = result_q;
    assign result_ovf_o = rovf_q;

endmodule

// File: tb/tb_accum_arbiter.sv
// tb_accum_arbiter: scoreboard bench for accum_arbiter with a behavioural accum
module tb_accum_arbiter;

    localparam int W = 8;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [L-1:0] len0 = '0, len1 = '0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         gnt0, gnt1, acc_clear, busy, done, done_id, result_ovf;
    logic [W-1:0] din1, din2, result;
    logic [W-1:0] acc;
    logic         acc_ovf;
    logic [W+1:0] sum;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic         id;
        int           beats;
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    accum_arbiter #(.WIDTH(W), .LENW(L)) dut (
        .clock_i(clk), .reset_i(rst_n),
        .req0_i(req0), .req1_i(req1), .len0_i(len0), .len1_i(len1),
        .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .acc_clear_o(acc_clear),
        .acc_din1_o(din1), .acc_din2_o(din2),
        .acc_result_i(acc), .acc_ovf_i(acc_ovf),
        .busy_o(busy), .done_o(done), .done_id_o(done_id),
        .result_o(result), .result_ovf_o(result_ovf)
    );

    // Accum model: acc += din1+din2 mod 2**W, overflow sticky until clear.
    assign sum = {2'b00, acc} + {2'b00, din1} + {2'b00, din2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (acc_clear) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else begin
            acc     <= sum[W-1:0];
            acc_ovf <= acc_ovf | (sum[W+1:W] != 2'b00);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Monitor: per-burst statistics, compared against the scoreboard on each done.
    initial begin
        int   beats = 0, clears = 0, since = 0;
        logic both = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                beats = 0; clears = 0; since = 0; both = 1'b0;
            end else begin
                if (gnt0 && gnt1) both = 1'b1;
                if (gnt0 || gnt1) begin
                    beats++;
                    since = 0;
                end else begin
                    since++;
                end
                if (acc_clear) clears++;
                if (done) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done_id %0d, expected no done", done_id);
                    end else begin
                        e = sb.pop_front();
                        check("done_id", 32'(done_id), 32'(e.id));
                        check("result", 32'(result), 32'(e.res));
                        check("result_ovf", 32'(result_ovf), 32'(e.ovf));
                        check("beats", 32'(beats), 32'(e.beats));
                        check("clear_cycles", 32'(clears), 32'd1);
                        check("done_latency", 32'(since), 32'd2);
                        check("gnt_overlap", 32'(both), 32'd0);
                    end
                    beats = 0; clears = 0; both = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic id, input int beats, input logic [W-1:0] res, input logic ovf);
        exp_t e;
        e.id = id; e.beats = beats; e.res = res; e.ovf = ovf;
        sb.push_back(e);
    endtask

    task automatic wait_gnt(input logic id);
        int n = 0;
        while (!(id ? gnt1 : gnt0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL gnt_timeout: got no gnt%0d, expected one within 100 cycles", id);
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got %0d bursts pending, expected 0", sb.size());
        end
    endtask

    initial begin
        int g;
        repeat (2) @(negedge clk);
        check("rst_gnt0", 32'(gnt0), 0);
        check("rst_gnt1", 32'(gnt1), 0);
        check("rst_clear", 32'(acc_clear), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        check("rst_din1", 32'(din1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T2: both requesting, alternation starting with requester 0.
        a0 = 8'h01; b0 = 8'h02; a1 = 8'h05; b1 = 8'h06;
        len0 = 4'h0; len1 = 4'h0;
        push(1'b0, 1, 8'h03, 1'b0);
        push(1'b1, 1, 8'h0B, 1'b0);
        push(1'b0, 1, 8'h03, 1'b0);
        push(1'b1, 1, 8'h0B, 1'b0);
        req0 = 1'b1; req1 = 1'b1;
        g = 0;
        for (int i = 0; i < 100 && g < 4; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) g++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("t2_grants", 32'(g), 4);
        wait_empty();

        // T1: single 4-beat burst from requester 0.
        @(negedge clk);
        len0 = 4'h3; a0 = 8'h03; b0 = 8'h01;
        push(1'b0, 4, 8'h10, 1'b0);
        req0 = 1'b1;
        wait_gnt(1'b0);
        req0 = 1'b0;
        wait_empty();

        // T3/T4: 16-beat burst that overflows.
        @(negedge clk);
        len1 = 4'hF; a1 = 8'h10; b1 = 8'h08;
`ifdef ACCUM_ARB_OVF_ABORT_EN
        push(1'b1, 12, 8'h20, 1'b1);
`else
        push(1'b1, 16, 8'h80, 1'b1);
`endif
        req1 = 1'b1;
        wait_gnt(1'b1);
        req1 = 1'b0;
        wait_empty();

        // T6: req dropped and len changed after the first beat.
        @(negedge clk);
        len0 = 4'h7; a0 = 8'h02; b0 = 8'h03;
        push(1'b0, 8, 8'h28, 1'b0);
        req0 = 1'b1;
        wait_gnt(1'b0);
        req0 = 1'b0;
        len0 = 4'h1;
        wait_empty();

        // T5: reset on the second RUN beat, then restart.
        @(negedge clk);
        len0 = 4'h3; a0 = 8'h01; b0 = 8'h01;
        req0 = 1'b1;
        wait_gnt(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_gnt0", 32'(gnt0), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_clear", 32'(acc_clear), 0);
        check("t5_result", 32'(result), 0);
        check("t5_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        len0 = 4'h1; a0 = 8'h04; b0 = 8'h04;
        push(1'b0, 2, 8'h10, 1'b0);
        rst_n = 1'b1;
        wait_gnt(1'b0);
        req0 = 1'b0;
        wait_empty();

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
